mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage LEGv8 pipeline, directly downstream of the execute stage. It registers the execute outputs and control bits (EX/MEM boundary), performs doubleword loads and stores against an internal data memory, and resolves the branch decision (`pc_src`) for fetch. Its registered outputs feed write-back.

## Interface
Parameters:
- `WORD`, 64 (from `definitions.vh`), datapath width.
- `DEPTH`, 64, data memory size in doublewords (power of two).
- `AW`, log2(DEPTH) = 6, memory index width.

Ports:
- `clk` input 1: the single clock.
- `reset_n` input 1: reset, synchronous and active-low.
- `valid_in` input 1: the execute stage presents a live instruction.
- `stall` input 1: hold all stage state; nothing is captured.
- `flush` input 1: squash the incoming instruction.
- `alu_result` input WORD: ALU result, used as the byte address for memory operations.
- `zero` input 1: ALU zero flag.
- `branch_target` input WORD: PC + (sign_extend × 4).
- `read_data2` input WORD: store data.
- `mem_read`, `mem_write`, `branch`, `uncond_branch`, `mem_to_reg`, `reg_write` input 1 each: control bits.
- `write_reg` input 5: destination register.
- `valid_out` output 1: the stage holds a live instruction.
- `pc_src` output 1: take the branch.
- `branch_target_out` output WORD: registered branch target.
- `read_data` output WORD: load data.
- `alu_result_out` output WORD: registered ALU result.
- `mem_to_reg_out`, `reg_write_out` output 1 each: write-back control.
- `write_reg_out` output 5: destination register.
- `misaligned` output 1: the captured memory op had `alu_result[2:0] != 0`.

## Operation
- Capture condition is `cap = valid_in & ~stall & ~flush`.
- On a clock edge with `cap`:
  - All `*_out` registers load their inputs.
  - `valid_out` is set to 1.
  - `pc_src` is set to `uncond_branch | (branch & zero)`.
- On an edge with `~stall & ~cap`:
  - `valid_out`, `pc_src`, `reg_write_out` and `misaligned` clear to 0.
  - The data registers may hold or load inputs; their values are don't-care.
- On an edge with `stall`: every register and the memory hold.
- `flush` without `stall` drops the incoming instruction and clears the stage per the rule above.
- `stall` has priority over `flush`.
- Memory indexing:
  - Index is `alu_result[AW+2:3]`.
  - Higher address bits are ignored, so accesses wrap modulo DEPTH×8 bytes.
- Alignment: `align_ok = (alu_result[2:0] == 0)`.
- Store: the memory word is written at an edge with `cap & mem_write & align_ok`.
- Load: on an edge with `cap & mem_read & align_ok`, `read_data` loads `mem[index]`.
- Misaligned accesses:
  - A misaligned store performs no write.
  - A misaligned load returns 0 in `read_data`.
  - Either sets `misaligned` = 1 while the instruction is in the stage.
  - `reg_write_out` is forced to 0 for a misaligned load.
- If `mem_read` and `mem_write` are both set: the store is performed, and `read_data` returns the pre-write contents (read-before-write).
- Non-memory instructions: `read_data` = 0, `misaligned` = 0.
- Memory contents are not reset. The bench preloads memory hierarchically or through stores.

## Timing
- Latency is 1 cycle: inputs at edge N appear on the outputs after edge N.
- Stores are visible to a load presented in the next cycle (back-to-back store→load at the same address returns new data).
- `pc_src` is valid only while `valid_out` = 1; fetch samples it combinationally from this register.
- Reset, at an edge with `reset_n` = 0:
  - All outputs go to 0: `valid_out`, `pc_src`, `read_data`, `alu_result_out`, `branch_target_out`, `mem_to_reg_out`, `reg_write_out`, `write_reg_out`, `misaligned`.
  - No memory write occurs in that cycle, even if `cap` and `mem_write` are asserted.
  - Reset overrides `stall`.
- Reset mid-operation: an instruction in the stage is discarded, and a store presented in the reset cycle is lost.
- Deassertion: the first capture happens at the first edge with `reset_n` = 1.

## Test plan
- Store/load:
  - Stimulus: STUR, `alu_result`=0x10, `read_data2`=0xDEADBEEF_01234567; then LDUR at 0x10 in the next cycle.
  - Required: `read_data`=0xDEADBEEF_01234567 one cycle later, with `valid_out`=1 and `mem_to_reg_out`=1.
- Branches:
  - CBZ (`branch`=1) with `zero`=1 and `branch_target`=0x40 → `pc_src`=1, `branch_target_out`=0x40.
  - CBZ with `zero`=0 → `pc_src`=0.
  - B (`uncond_branch`=1) → `pc_src`=1 regardless of `zero`.
- Stall and flush:
  - Hold `stall` for 3 cycles while inputs change → outputs are frozen and memory is unchanged.
  - STUR with `flush`=1 → no write (a later load returns the old value) and `valid_out`=0.
- Misaligned and wrap:
  - STUR at 0x13 → memory unchanged and `misaligned`=1.
  - LDUR at 0x13 → `read_data`=0 and `reg_write_out`=0.
  - Store at 0x210 then load at 0x010 (DEPTH=64) → the stored value is returned.
- Reset:
  - Pull `reset_n` low in the same cycle as a STUR to 0x8 → all outputs are 0 next cycle, and a load of 0x8 after release returns the prior contents.

Source files
------------

// File: rtl/mem_stage_if.sv
// EX/MEM boundary bundle: execute-side request and control bits in,
// write-back results and branch decision out.
interface mem_stage_if #(
   parameter int WORD = 64
);
   logic            valid_in;
   logic            stall;
   logic            flush;
   logic [WORD-1:0] alu_result;
   logic            zero;
   logic [WORD-1:0] branch_target;
   logic [WORD-1:0] read_data2;
   logic            mem_read;
   logic            mem_write;
   logic            branch;
   logic            uncond_branch;
   logic            mem_to_reg;
   logic            reg_write;
   logic [4:0]      write_reg;

   logic            valid_out;
   logic            pc_src;
   logic [WORD-1:0] branch_target_out;
   logic [WORD-1:0] read_data;
   logic [WORD-1:0] alu_result_out;
   logic            mem_to_reg_out;
   logic            reg_write_out;
   logic [4:0]      write_reg_out;
   logic            misaligned;

   modport master (
      output valid_in, stall, flush, alu_result, zero, branch_target, read_data2,
             mem_read, mem_write, branch, uncond_branch, mem_to_reg, reg_write, write_reg,
      input  valid_out, pc_src, branch_target_out, read_data, alu_result_out,
             mem_to_reg_out, reg_write_out, write_reg_out, misaligned
   );

   modport slave (
      input  valid_in, stall, flush, alu_result, zero, branch_target, read_data2,
             mem_read, mem_write, branch, uncond_branch, mem_to_reg, reg_write, write_reg,
      output valid_out, pc_src, branch_target_out, read_data, alu_result_out,
             mem_to_reg_out, reg_write_out, write_reg_out, misaligned
   );
endinterface

// File: rtl/mem_stage.sv
// LEGv8 memory-access stage: EX/MEM pipeline register, doubleword data memory
// and branch resolution feeding fetch.
module mem_stage #(
   parameter int WORD  = 64,
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        reset_n,
   mem_stage_if.slave  bus
);

   logic [WORD-1:0] mem_q [DEPTH];

   logic            valid_q, valid_d;
   logic            pc_src_q, pc_src_d;
   logic [WORD-1:0] branch_target_q, branch_target_d;
   logic [WORD-1:0] read_data_q, read_data_d;
   logic [WORD-1:0] alu_result_q, alu_result_d;
   logic            mem_to_reg_q, mem_to_reg_d;
   logic            reg_write_q, reg_write_d;
   logic [4:0]      write_reg_q, write_reg_d;
   logic            misaligned_q, misaligned_d;

   logic            cap_s;
   logic            align_ok_s;
   logic [AW-1:0]   index_s;
   logic            wr_en_s;
   logic [WORD-1:0] mem_rd_s;

   assign cap_s      = bus.valid_in & ~bus.stall & ~bus.flush;
   assign align_ok_s = (bus.alu_result[2:0] == 3'd0);
   // Upper address bits are dropped, so accesses wrap around the array.
   assign index_s    = bus.alu_result[AW+2:3];
   assign wr_en_s    = reset_n & cap_s & bus.mem_write & align_ok_s;
   assign mem_rd_s   = mem_q[index_s];

   // Data memory write port; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_q[index_s] <= bus.read_data2;
      end
   end

   // Next-state for the EX/MEM register: stall holds, capture loads, otherwise squash.
   always_comb begin
      valid_d         = valid_q;
      pc_src_d        = pc_src_q;
      branch_target_d = branch_target_q;
      read_data_d     = read_data_q;
      alu_result_d    = alu_result_q;
      mem_to_reg_d    = mem_to_reg_q;
      reg_write_d     = reg_write_q;
      write_reg_d     = write_reg_q;
      misaligned_d    = misaligned_q;
      if (bus.stall) begin
         valid_d      = valid_q;
         pc_src_d     = pc_src_q;
         reg_write_d  = reg_write_q;
         misaligned_d = misaligned_q;
      end else if (cap_s) begin
         valid_d         = 1'b1;
         pc_src_d        = bus.uncond_branch | (bus.branch & bus.zero);
         branch_target_d = bus.branch_target;
         alu_result_d    = bus.alu_result;
         mem_to_reg_d    = bus.mem_to_reg;
         write_reg_d     = bus.write_reg;
         // mem_rd_s is the pre-write word, giving read-before-write when both ops are set.
         if (bus.mem_read && align_ok_s) begin
            read_data_d = mem_rd_s;
         end else begin
            read_data_d = {WORD{1'b0}};
         end
         misaligned_d = (bus.mem_read | bus.mem_write) & ~align_ok_s;
         reg_write_d  = bus.reg_write & ~(bus.mem_read & ~align_ok_s);
      end else begin
         valid_d      = 1'b0;
         pc_src_d     = 1'b0;
         reg_write_d  = 1'b0;
         misaligned_d = 1'b0;
      end
   end

   // EX/MEM register with synchronous active-low reset overriding stall.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid_q         <= 1'b0;
         pc_src_q        <= 1'b0;
         branch_target_q <= {WORD{1'b0}};
         read_data_q     <= {WORD{1'b0}};
         alu_result_q    <= {WORD{1'b0}};
         mem_to_reg_q    <= 1'b0;
         reg_write_q     <= 1'b0;
         write_reg_q     <= 5'd0;
         misaligned_q    <= 1'b0;
      end else begin
         valid_q         <= valid_d;
         pc_src_q        <= pc_src_d;
         branch_target_q <= branch_target_d;
         read_data_q     <= read_data_d;
         alu_result_q    <= alu_result_d;
         mem_to_reg_q    <= mem_to_reg_d;
         reg_write_q     <= reg_write_d;
         write_reg_q     <= write_reg_d;
         misaligned_q    <= misaligned_d;
      end
   end

   assign bus.valid_out         = valid_q;
   assign bus.pc_src            = pc_src_q;
   assign bus.branch_target_out = branch_target_q;
   assign bus.read_data         = read_data_q;
   assign bus.alu_result_out    = alu_result_q;
   assign bus.mem_to_reg_out    = mem_to_reg_q;
   assign bus.reg_write_out     = reg_write_q;
   assign bus.write_reg_out     = write_reg_q;
   assign bus.misaligned        = misaligned_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed, table-driven bench for mem_stage with hand-computed expectations.
module tb_mem_stage;

   typedef struct {
      logic        rst_n, vin, stall, flush;
      logic [63:0] alu;
      logic        zero;
      logic [63:0] bt, wd;
      logic        mr, mw, br, ub, m2r, rw;
      logic [4:0]  wreg;
   } in_t;

   typedef struct {
      logic        valid, pc;
      logic [63:0] bt, rd, alu;
      logic        m2r, rw;
      logic [4:0]  wreg;
      logic        mis;
      logic        ctrl_only;
   } exp_t;

   typedef struct {
      string name;
      in_t   i;
      exp_t  e;
   } vec_t;

   localparam logic [63:0] D1 = 64'hDEADBEEF_01234567;

   logic clk = 1'b0;
   logic reset_n;
   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   mem_stage_if #(.WORD(64)) bus ();

   mem_stage #(.WORD(64), .DEPTH(64)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   function automatic in_t f_idle();
      in_t r;
      r = '{1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 64'd0,
            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
      return r;
   endfunction

   function automatic in_t f_stur(logic [63:0] a, logic [63:0] d);
      in_t r;
      r = f_idle();
      r.vin = 1'b1; r.alu = a; r.wd = d; r.mw = 1'b1;
      return r;
   endfunction

   function automatic in_t f_ldur(logic [63:0] a, logic [4:0] w);
      in_t r;
      r = f_idle();
      r.vin = 1'b1; r.alu = a; r.mr = 1'b1; r.m2r = 1'b1; r.rw = 1'b1; r.wreg = w;
      return r;
   endfunction

   function automatic in_t f_br(logic uncond, logic z, logic [63:0] a, logic [63:0] t);
      in_t r;
      r = f_idle();
      r.vin = 1'b1; r.ub = uncond; r.br = ~uncond; r.zero = z; r.alu = a; r.bt = t;
      return r;
   endfunction

   function automatic exp_t e_mk(logic v, logic pc, logic [63:0] bt, logic [63:0] rd,
                                 logic [63:0] alu, logic m2r, logic rw, logic [4:0] w,
                                 logic mis, logic co);
      exp_t r;
      r = '{v, pc, bt, rd, alu, m2r, rw, w, mis, co};
      return r;
   endfunction

   function automatic exp_t e_zero();
      return e_mk(1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endfunction

   function automatic exp_t e_squash();
      return e_mk(1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
   endfunction

   task automatic chk(string nm, string f, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s.%s: got %h expected %h", nm, f, act, exp);
      end
   endtask

   task automatic apply(string nm, in_t i, exp_t e);
      reset_n           = i.rst_n;
      bus.valid_in      = i.vin;
      bus.stall         = i.stall;
      bus.flush         = i.flush;
      bus.alu_result    = i.alu;
      bus.zero          = i.zero;
      bus.branch_target = i.bt;
      bus.read_data2    = i.wd;
      bus.mem_read      = i.mr;
      bus.mem_write     = i.mw;
      bus.branch        = i.br;
      bus.uncond_branch = i.ub;
      bus.mem_to_reg    = i.m2r;
      bus.reg_write     = i.rw;
      bus.write_reg     = i.wreg;
      @(posedge clk);
      #1;
      chk(nm, "valid_out", {63'd0, bus.valid_out}, {63'd0, e.valid});
      chk(nm, "pc_src", {63'd0, bus.pc_src}, {63'd0, e.pc});
      chk(nm, "reg_write_out", {63'd0, bus.reg_write_out}, {63'd0, e.rw});
      chk(nm, "misaligned", {63'd0, bus.misaligned}, {63'd0, e.mis});
      if (!e.ctrl_only) begin
         chk(nm, "branch_target_out", bus.branch_target_out, e.bt);
         chk(nm, "read_data", bus.read_data, e.rd);
         chk(nm, "alu_result_out", bus.alu_result_out, e.alu);
         chk(nm, "mem_to_reg_out", {63'd0, bus.mem_to_reg_out}, {63'd0, e.m2r});
         chk(nm, "write_reg_out", {59'd0, bus.write_reg_out}, {59'd0, e.wreg});
      end
      @(negedge clk);
   endtask

   initial begin
      in_t  i;
      exp_t held;

      tbl.push_back('{"stur_10", f_stur(64'h10, D1),
                      e_mk(1'b1, 1'b0, 64'd0, 64'd0, 64'h10, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0)});
      tbl.push_back('{"ldur_10", f_ldur(64'h10, 5'd5),
                      e_mk(1'b1, 1'b0, 64'd0, D1, 64'h10, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0)});
      tbl.push_back('{"cbz_taken", f_br(1'b0, 1'b1, 64'd0, 64'h40),
                      e_mk(1'b1, 1'b1, 64'h40, 64'd0, 64'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0)});
      tbl.push_back('{"cbz_not", f_br(1'b0, 1'b0, 64'd5, 64'h80),
                      e_mk(1'b1, 1'b0, 64'h80, 64'd0, 64'd5, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0)});
      tbl.push_back('{"b_uncond", f_br(1'b1, 1'b0, 64'd7, 64'h100),
                      e_mk(1'b1, 1'b1, 64'h100, 64'd0, 64'd7, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0)});
      tbl.push_back('{"bubble", f_idle(), e_squash()});
      tbl.push_back('{"stur_18", f_stur(64'h18, 64'h1111),
                      e_mk(1'b1, 1'b0, 64'd0, 64'd0, 64'h18, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0)});
      i = f_stur(64'h18, 64'h2222); i.flush = 1'b1;
      tbl.push_back('{"stur_flush", i, e_squash()});
      tbl.push_back('{"ldur_18_old", f_ldur(64'h18, 5'd6),
                      e_mk(1'b1, 1'b0, 64'd0, 64'h1111, 64'h18, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0)});
      tbl.push_back('{"stur_mis", f_stur(64'h13, 64'h3333),
                      e_mk(1'b1, 1'b0, 64'd0, 64'd0, 64'h13, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0)});
      tbl.push_back('{"ldur_mis", f_ldur(64'h13, 5'd4),
                      e_mk(1'b1, 1'b0, 64'd0, 64'd0, 64'h13, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0)});
      tbl.push_back('{"ldur_10_kept", f_ldur(64'h10, 5'd5),
                      e_mk(1'b1, 1'b0, 64'd0, D1, 64'h10, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0)});
      tbl.push_back('{"stur_210", f_stur(64'h210, 64'hCAFE),
                      e_mk(1'b1, 1'b0, 64'd0, 64'd0, 64'h210, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0)});
      tbl.push_back('{"ldur_wrap", f_ldur(64'h10, 5'd2),
                      e_mk(1'b1, 1'b0, 64'd0, 64'hCAFE, 64'h10, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0)});
      tbl.push_back('{"stur_1f8", f_stur(64'h1F8, 64'h77),
                      e_mk(1'b1, 1'b0, 64'd0, 64'd0, 64'h1F8, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0)});
      tbl.push_back('{"ldur_3f8", f_ldur(64'h3F8, 5'd31),
                      e_mk(1'b1, 1'b0, 64'd0, 64'h77, 64'h3F8, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0)});
      tbl.push_back('{"stur_20", f_stur(64'h20, 64'hAAAA),
                      e_mk(1'b1, 1'b0, 64'd0, 64'd0, 64'h20, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0)});
      i = f_ldur(64'h20, 5'd9); i.mw = 1'b1; i.wd = 64'hBBBB;
      tbl.push_back('{"rd_wr_same", i,
                      e_mk(1'b1, 1'b0, 64'd0, 64'hAAAA, 64'h20, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0)});
      tbl.push_back('{"ldur_20_new", f_ldur(64'h20, 5'd9),
                      e_mk(1'b1, 1'b0, 64'd0, 64'hBBBB, 64'h20, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0)});

      reset_n = 1'b0;
      @(negedge clk);
      i = f_idle(); i.rst_n = 1'b0;
      apply("reset0", i, e_zero());
      apply("reset1", i, e_zero());

      for (int k = 0; k < tbl.size(); k++) begin
         apply(tbl[k].name, tbl[k].i, tbl[k].e);
      end

      // Stall for three cycles with changing inputs: everything frozen.
      held = e_mk(1'b1, 1'b0, 64'd0, 64'h1111, 64'h18, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
      apply("pre_stall", f_ldur(64'h18, 5'd7), held);
      i = f_stur(64'h18, 64'h9999); i.stall = 1'b1;
      apply("stall1", i, held);
      i = f_ldur(64'h10, 5'd3); i.stall = 1'b1; i.flush = 1'b1;
      apply("stall2_flush", i, held);
      i = f_br(1'b1, 1'b1, 64'd0, 64'h200); i.stall = 1'b1;
      apply("stall3", i, held);
      apply("post_stall", f_ldur(64'h18, 5'd8),
            e_mk(1'b1, 1'b0, 64'd0, 64'h1111, 64'h18, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0));

      // Reset coinciding with a store: outputs cleared and the store is lost.
      apply("stur_8", f_stur(64'h8, 64'h5555),
            e_mk(1'b1, 1'b0, 64'd0, 64'd0, 64'h8, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0));
      i = f_stur(64'h8, 64'h7777); i.rst_n = 1'b0;
      apply("reset_stur", i, e_zero());
      apply("ldur_8_after", f_ldur(64'h8, 5'd1),
            e_mk(1'b1, 1'b0, 64'd0, 64'h5555, 64'h8, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0));
      i = f_br(1'b1, 1'b0, 64'd0, 64'h44); i.rst_n = 1'b0; i.stall = 1'b1;
      apply("reset_over_stall", i, e_zero());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
